// File: rtl/json_cmd_rx.sv
// JSON motor-command frame receiver: parses {"T":n,"L":x,"R":y}\n from a UART
// byte stream into signed fixed-point speeds with a one-cycle commit strobe.
module json_cmd_rx #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int FRAC_DIGITS    = 3,
    parameter int INT_DIGITS     = 1,
    parameter int VAL_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    cmd_valid,
    output logic [7:0]              cmd_type,
    output logic signed [VAL_W-1:0] left_speed,
    output logic signed [VAL_W-1:0] right_speed,
    output logic [2:0]              field_mask,
    output logic                    parse_error,
    output logic                    busy
);

    localparam int MAG_W = 32;
    localparam int CNT_W = 4;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MAG_W-1:0] VAL_MAX = MAG_W'((64'd1 << (VAL_W - 1)) - 64'd1);

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SP     = 8'h20;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY_OPEN, S_KEY, S_KEY_CLOSE, S_COLON,
        S_SIGN, S_INT, S_FRAC, S_CLOSE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {K_T, K_L, K_R, K_X} key_t;

    state_t state, state_n;
    key_t   key, key_in;

    logic                    neg;
    logic [MAG_W-1:0]        mag, mag_acc, scaled;
    logic [VAL_W-1:0]        mag_sat;
    logic signed [VAL_W-1:0] value;
    logic [CNT_W-1:0]        int_cnt, frac_cnt, int_lim;
    logic [7:0]              sh_t;
    logic signed [VAL_W-1:0] sh_l, sh_r;
    logic [2:0]              sh_mask;
    logic [TO_W-1:0]         to_cnt;

    logic is_digit, is_ws, is_dot, is_end, timeout;
    logic err, commit, clr, key_ld, set_neg, int_dig, frac_dig, val_end, bad;

    assign busy     = (state != S_IDLE);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_ws    = (rx_data == CH_SP) || (rx_data == CH_CR);
    assign is_dot   = (rx_data == CH_DOT);
    assign is_end   = (rx_data == CH_COMMA) || (rx_data == CH_RBRACE);
    assign mag_acc  = (mag << 3) + (mag << 1) + MAG_W'(rx_data[3:0]);
    assign int_lim  = (key == K_T) ? CNT_W'(3) : CNT_W'(INT_DIGITS);
    assign timeout  = busy && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        key_in = K_X;
        unique case (rx_data)
            8'h54:   key_in = K_T;
            8'h4C:   key_in = K_L;
            8'h52:   key_in = K_R;
            default: key_in = K_X;
        endcase
    end

    // Pad missing fractional digits, saturate, then apply the sign.
    always_comb begin
        scaled = mag;
        for (int i = 0; i < FRAC_DIGITS; i++) begin
            if (CNT_W'(i) >= frac_cnt) scaled = (scaled << 3) + (scaled << 1);
        end
        mag_sat = (scaled > VAL_MAX) ? VAL_MAX[VAL_W-1:0] : scaled[VAL_W-1:0];
        value   = neg ? -$signed(mag_sat) : $signed(mag_sat);
    end

    always_comb begin
        state_n  = state;
        err      = 1'b0;
        commit   = 1'b0;
        clr      = 1'b0;
        key_ld   = 1'b0;
        set_neg  = 1'b0;
        int_dig  = 1'b0;
        frac_dig = 1'b0;
        val_end  = 1'b0;
        bad      = 1'b0;
        if (timeout) begin
            state_n = S_IDLE;
            err     = (state != S_ERROR);
            clr     = 1'b1;
        end else if (rx_valid && !is_ws) begin
            if (rx_data == CH_LBRACE) begin
                state_n = S_KEY_OPEN;
                clr     = 1'b1;
                err     = (state != S_IDLE) && (state != S_ERROR);
            end else begin
                unique case (state)
                    S_IDLE: state_n = S_IDLE;
                    S_ERROR: if (rx_data == CH_NL) state_n = S_IDLE;
                    S_KEY_OPEN: begin
                        if (rx_data == CH_QUOTE) state_n = S_KEY;
                        else if (rx_data == CH_RBRACE) state_n = S_CLOSE;
                        else bad = 1'b1;
                    end
                    S_KEY: begin
                        key_ld  = 1'b1;
                        state_n = S_KEY_CLOSE;
                    end
                    S_KEY_CLOSE: begin
                        if (rx_data == CH_QUOTE) state_n = S_COLON;
                        else bad = 1'b1;
                    end
                    S_COLON: begin
                        if (rx_data == CH_COLON) state_n = S_SIGN;
                        else bad = 1'b1;
                    end
                    S_SIGN: begin
                        if (rx_data == CH_MINUS && !neg && key != K_T) begin
                            set_neg = 1'b1;
                        end else if (is_digit) begin
                            int_dig = 1'b1;
                            state_n = S_INT;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    S_INT: begin
                        unique case (1'b1)
                            is_digit: begin
                                if (int_cnt >= int_lim) bad = 1'b1;
                                else if (key == K_T && mag_acc > MAG_W'(255)) bad = 1'b1;
                                else int_dig = 1'b1;
                            end
                            is_dot: begin
                                if (key == K_T) bad = 1'b1;
                                else state_n = S_FRAC;
                            end
                            is_end: begin
                                val_end = 1'b1;
                                state_n = (rx_data == CH_COMMA) ? S_KEY_OPEN : S_CLOSE;
                            end
                            default: bad = 1'b1;
                        endcase
                    end
                    S_FRAC: begin
                        unique case (1'b1)
                            is_digit: frac_dig = 1'b1;
                            is_end: begin
                                val_end = 1'b1;
                                state_n = (rx_data == CH_COMMA) ? S_KEY_OPEN : S_CLOSE;
                            end
                            default: bad = 1'b1;
                        endcase
                    end
                    S_CLOSE: begin
                        if (rx_data == CH_NL) begin
                            commit  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    state_n = S_ERROR;
                    err     = 1'b1;
                    clr     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key         <= K_X;
            neg         <= 1'b0;
            mag         <= '0;
            int_cnt     <= '0;
            frac_cnt    <= '0;
            sh_t        <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
            sh_mask     <= '0;
            to_cnt      <= '0;
            cmd_valid   <= 1'b0;
            parse_error <= 1'b0;
            cmd_type    <= '0;
            left_speed  <= '0;
            right_speed <= '0;
            field_mask  <= '0;
        end else begin
            cmd_valid   <= commit;
            parse_error <= err;
            to_cnt      <= (rx_valid || !busy) ? '0 : to_cnt + TO_W'(1);
            if (clr) sh_mask <= '0;
            if (key_ld) begin
                key      <= key_in;
                neg      <= 1'b0;
                mag      <= '0;
                int_cnt  <= '0;
                frac_cnt <= '0;
            end
            if (set_neg) neg <= 1'b1;
            if (int_dig) begin
                mag     <= mag_acc;
                int_cnt <= int_cnt + CNT_W'(1);
            end
            // Digits past the retained precision are swallowed (truncation).
            if (frac_dig && frac_cnt < CNT_W'(FRAC_DIGITS)) begin
                mag      <= mag_acc;
                frac_cnt <= frac_cnt + CNT_W'(1);
            end
            if (val_end) begin
                unique case (key)
                    K_T: begin
                        sh_t       <= mag[7:0];
                        sh_mask[2] <= 1'b1;
                    end
                    K_L: begin
                        sh_l       <= value;
                        sh_mask[1] <= 1'b1;
                    end
                    K_R: begin
                        sh_r       <= value;
                        sh_mask[0] <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                if (sh_mask[2]) cmd_type    <= sh_t;
                if (sh_mask[1]) left_speed  <= sh_l;
                if (sh_mask[0]) right_speed <= sh_r;
                field_mask <= sh_mask;
            end
        end
    end

endmodule

// File: tb/tb_json_cmd_rx.sv
// Scoreboard bench for json_cmd_rx: expected commits queued as frames are
// sent, popped and compared when cmd_valid fires.
module tb_json_cmd_rx;

    localparam int TO = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              cmd_valid;
    logic [7:0]        cmd_type;
    logic signed [15:0] left_speed;
    logic signed [15:0] right_speed;
    logic [2:0]        field_mask;
    logic              parse_error;
    logic              busy;

    typedef struct {
        longint t;
        longint l;
        longint r;
        longint m;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cyc = 0;
    int err_seen = 0;
    int exp_err = 0;
    int err_cyc = 0;
    int commits = 0;
    int pushed = 0;

    json_cmd_rx #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .left_speed (left_speed),
        .right_speed(right_speed),
        .field_mask (field_mask),
        .parse_error(parse_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input longint t, input longint l, input longint r, input longint m);
        q.push_back('{t, l, r, m});
        pushed++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        last_cyc = cyc;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (parse_error) begin
            err_seen = err_seen + 1;
            err_cyc  = cyc;
        end
        if (cmd_valid) begin
            commits = commits + 1;
            chk("lat", cyc - last_cyc, 0);
            if (q.size() == 0) begin
                chk("extra_cmd", 1, 0);
            end else begin
                e = q.pop_front();
                chk("type", cmd_type, e.t);
                chk("left", left_speed, e.l);
                chk("right", right_speed, e.r);
                chk("mask", field_mask, e.m);
            end
        end
    end

    initial begin
        int e0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_type", cmd_type, 0);
        chk("rst_left", left_speed, 0);
        chk("rst_right", right_speed, 0);
        chk("rst_mask", field_mask, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_err", parse_error, 0);

        push(1, -250, 250, 7);
        send_str("{\"T\":1,\"L\":-0.25,\"R\":0.25}\n", 433);
        settle();
        chk("t1_err", err_seen, exp_err);
        chk("t1_q", q.size(), 0);

        push(1, 500, 123, 7);
        send_str("{\"T\":1,\"L\":0.5,\"R\":0.1239}\n", 3);
        push(1, 0, 123, 2);
        send_str("{\"L\":0}\n", 3);
        settle();
        chk("t2_q", q.size(), 0);

        exp_err++;
        send_str("{\"T\":1,\"L\":x}\n", 3);
        settle();
        chk("t3_err", err_seen, exp_err);
        chk("t3_type", cmd_type, 1);
        chk("t3_left", left_speed, 0);
        chk("t3_right", right_speed, 123);
        chk("t3_mask", field_mask, 2);
        push(2, -125, 1000, 7);
        send_str("{\"T\":2,\"L\":-0.125,\"R\":1}\n", 3);
        settle();
        chk("t3_q", q.size(), 0);

        exp_err++;
        push(3, 0, 0, 7);
        send_str("ab{\"T\":1,\"L\":0.2{\"T\":3,\"L\":0,\"R\":0}\n", 2);
        settle();
        chk("t4_err", err_seen, exp_err);
        chk("t4_q", q.size(), 0);

        exp_err++;
        e0 = err_seen;
        n  = 0;
        send_str("{\"T\":", 2);
        chk("to_busy0", busy, 1);
        while (err_seen == e0 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        if (err_seen == e0) chk("to_wait", 0, 1);
        else chk("to_lat", err_cyc - last_cyc, TO);
        chk("to_busy", busy, 0);
        push(3, 0, -500, 1);
        send_str("{\"R\":-0.5}\n", 2);
        settle();
        chk("t5_err", err_seen, exp_err);
        chk("t5_q", q.size(), 0);

        send_str("{\"T\":7,\"L\":0.5", 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_type", cmd_type, 0);
        chk("mid_left", left_speed, 0);
        chk("mid_right", right_speed, 0);
        chk("mid_mask", field_mask, 0);
        chk("mid_busy", busy, 0);
        exp_err++;
        send_str("{\"T\":256}\n", 2);
        settle();
        chk("t256_err", err_seen, exp_err);
        chk("t256_type", cmd_type, 0);
        push(0, -9999, 0, 2);
        send_str("{\"L\":-9.9999}\n", 2);
        settle();
        chk("t6_q", q.size(), 0);

        exp_err++;
        send_str("{\"L\":12}\n", 2);
        push(0, -9999, 0, 0);
        send_str("{}\n", 2);
        push(0, -9999, 5000, 1);
        send_str("{\"R\":5.}\n", 2);
        exp_err++;
        send_str("{\"L\":-,\"R\":1}\n", 2);
        exp_err++;
        send_str("{\"T\":-1}\n", 2);
        push(9, -9999, 5000, 4);
        send_str("{\"X\":3,\"T\":9}\n", 2);
        push(6, -9999, 5000, 4);
        send_str("{\"T\":5,\"T\":6}\n", 2);
        push(4, -9999, 5000, 4);
        send_str(" { \"T\" : 4 }\r\n", 2);

        repeat (10) @(posedge clk);
        #1;
        chk("end_q", q.size(), 0);
        chk("end_err", err_seen, exp_err);
        chk("end_commits", commits, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/json_cmd_rx.md
Name: json_cmd_rx

Overview:
- Receive-side counterpart of the team's JSON motor-command UART transmitter.
- Consumes the byte stream from a uart_rx instance and parses command frames of the form {"T":1,"L":-0.25,"R":0.25}\n.
- Presents the decoded command type and left/right speeds as signed fixed-point values with a one-cycle commit strobe.
- Sits between uart_rx and the drive/state logic. Used for loopback checking and for robot-to-FPGA command/feedback links.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock frequency; informational only.
- TIMEOUT_CYCLES, 5_000_000, maximum idle cycles between bytes inside a frame before abort (100 ms).
- FRAC_DIGITS, 3, fractional digits retained; value scale is 10^FRAC_DIGITS.
- INT_DIGITS, 1, maximum integer-part digits for L/R.
- VAL_W, 16, width of the signed speed outputs.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte; no backpressure, so one byte must be accepted every cycle
- cmd_valid  out  1  one-cycle pulse on each committed frame
- cmd_type  out  8  last committed T value
- left_speed  out  VAL_W  signed L value, scaled ×10^FRAC_DIGITS
- right_speed  out  VAL_W  signed R value, scaled ×10^FRAC_DIGITS
- field_mask  out  3  {T,L,R} keys present in the last committed frame
- parse_error  out  1  one-cycle pulse when a frame is aborted
- busy  out  1  high while inside a frame (not IDLE)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset asserted mid-frame discards the partial frame, and no strobe is generated.
- Spaces (0x20) and CR (0x0D) are ignored in every state.
- States:
  - IDLE: waits for '{'; all other bytes are ignored.
  - KEY_OPEN: expects '"'.
  - KEY: accepts one byte as the key. 'T', 'L' and 'R' are known; any other byte is an unknown key whose value is parsed and discarded.
  - KEY_CLOSE: expects '"'.
  - COLON: expects ':'.
  - SIGN: accepts an optional '-' (0x2D), then a digit.
  - INT: accepts digits; '.' goes to FRAC; ',' or '}' ends the value.
  - FRAC: accepts digits; ',' or '}' ends the value.
  - CLOSE: after '}', expects '\n' (0x0A).
  - ERROR: waits for '\n' or '{'.
- Transitions out of a value:
  - ',' returns to KEY_OPEN.
  - '}' goes to CLOSE.
  - '\n' in CLOSE commits the frame and returns to IDLE.
- Value arithmetic:
  - Magnitude accumulator: mag = mag×10 + digit.
  - Fractional digits beyond FRAC_DIGITS are accepted and truncated (not rounded).
  - At value end, missing fractional digits are padded by ×10 per digit.
  - The sign is then applied.
  - The result saturates to ±(2^(VAL_W-1)-1).
- T field rules:
  - Unsigned integer, at most 3 digits, value ≤255.
  - '-', '.', or a value >255 is an error.
- Digit-count limits:
  - More than INT_DIGITS integer digits in L/R is an error.
  - A value with no digits is an error (e.g. "-," or "."). "5." is legal.
- Staging and commit:
  - Parsed fields go to shadow registers plus a shadow mask.
  - Duplicate keys: last occurrence wins.
  - On commit:
    - Fields present in the shadow mask update their outputs.
    - Absent fields keep their previous output values.
    - field_mask is set to the shadow mask.
    - cmd_valid pulses for one cycle.
  - Latency: outputs and cmd_valid change on the clock edge after the '\n' byte's rx_valid cycle. For example, '\n' sampled at edge N makes cmd_valid high during cycle N+1.
  - An empty frame "{}\n" is legal: it commits with field_mask=0 and leaves outputs unchanged.
- Errors:
  - Error causes: an unexpected byte in any non-IDLE state, a range violation, or a timeout.
  - Response:
    - parse_error pulses for one cycle.
    - The shadow registers are discarded.
    - The FSM enters ERROR.
    - Outputs are not changed.
  - In ERROR, '\n' goes to IDLE and '{' starts a new frame directly. This transition produces no second error pulse.
- Resync: '{' received in any in-frame state other than ERROR aborts the current frame (parse_error pulse) and restarts at KEY_OPEN.
- Timeout:
  - The timeout counter resets on every rx_valid.
  - It counts only while busy.
  - On reaching TIMEOUT_CYCLES it gives an error pulse and the FSM returns to IDLE (not ERROR).
- Simultaneous events: reset dominates. No further strobe can coincide with cmd_valid, because the next byte starts in IDLE.

Test Plan:
- Send {"T":1,"L":-0.25,"R":0.25}\n one byte every 434 clocks → a single cmd_valid pulse one cycle after '\n'; cmd_type=1, left_speed=-250, right_speed=250, field_mask=3'b111; parse_error never asserted.
- Send {"T":1,"L":0.5,"R":0.1239}\n, then {"L":0}\n → first frame gives left=500, right=123. Second frame gives left=0, right stays 123, cmd_type stays 1, field_mask=3'b010.
- Send {"T":1,"L":x}\n and then a valid frame → parse_error pulses once on 'x' and outputs are unchanged. The following valid frame commits normally.
- Inject garbage "ab" before '{', then send {"T":1,"L":0.2{"T":3,"L":0,"R":0}\n → garbage is ignored; one parse_error at the second '{'; commit with cmd_type=3, left=0, right=0.
- Stop mid-frame after {"T": for TIMEOUT_CYCLES cycles (set to 1000 for the test) → parse_error at cycle 1000 and busy=0. A subsequent valid frame commits.
- Assert rst for one cycle mid-frame → all outputs 0 and no cmd_valid. Then send {"T":256}\n → parse_error and no commit. Finally send {"L":-9.9999}\n → left_speed=-9999.
